// File: rtl/nn_pkg.sv
// Shared Q8.8 constants, FSM state type and saturating arithmetic for the
// neuron datapath.
package nn_pkg;

  localparam int FRAC_BITS = 8;
  localparam int DATA_W    = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] data;
  } result_t;

  // Adds two sign-extended operands and clamps the sum to a w-bit signed range.
  // Callers keep their operands inside w bits, so the 64-bit sum cannot wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int              w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/neuron_acc_tag_delay.sv
// Tag delay line matching the multiplier latency. It also counts the
// valid-and-last tags it is holding, which feeds the output credit check.
module tag_delay #(
  parameter int LAT   = 5,
  parameter int CNT_W = $clog2(LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             out_valid,
  output logic             out_last,
  output logic             any_valid,
  output logic [CNT_W-1:0] last_count
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] last_q;

  // Shift tags one stage per edge; last is stored already qualified by valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_valid & in_last;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  // Population count of last tags across all stages.
  always_comb begin
    last_count = '0;
    for (int i = 0; i < LAT; i++) begin
      last_count = last_count + CNT_W'(last_q[i]);
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_last  = last_q[LAT-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/neuron_acc.sv
// Accumulate-and-activate stage behind the pipelined 8.8 multiplier: sums one
// vector of products, adds bias, clips to 8.8, optional ReLU, and queues the
// result in a credit-protected output FIFO.
//
// state    | meaning
// ST_EMPTY | accumulator is zero, no vector in progress
// ST_ACCUM | acc_q holds the partial sum of the current vector
module neuron_acc
  import nn_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int ACC_W    = 24,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_last,
  output logic              op_ready,
  input  logic [DATA_W-1:0] prod,
  input  logic [DATA_W-1:0] bias,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W  = $clog2(MULT_LAT + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  logic                    accept;
  logic                    tag_valid;
  logic                    tag_last;
  logic                    tag_any;
  logic [CNT_W-1:0]        lasts_in_flight;

  acc_state_t              state_q;
  acc_state_t              state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W:0]   fin_sum;
  logic                    push;
  result_t                 push_res;

  result_t                 fifo_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [FCNT_W-1:0]       fifo_count;
  logic                    pop;

  assign accept = op_valid & op_ready;

  tag_delay #(
    .LAT   (MULT_LAT),
    .CNT_W (CNT_W)
  ) u_tag_delay (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (accept),
    .in_last    (op_last),
    .out_valid  (tag_valid),
    .out_last   (tag_last),
    .any_valid  (tag_any),
    .last_count (lasts_in_flight)
  );

  // Every last already in the pipe owns a FIFO slot, so the multiplier never
  // needs to stall; only registered state feeds this.
  assign op_ready = (32'(fifo_count) + 32'(lasts_in_flight)) < 32'(DEPTH);

  // State and accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next state: accumulate aligned products, finish the vector on last.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    push     = 1'b0;
    push_res = '0;
    fin_sum  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(signed'(prod)) + (ACC_W+1)'(signed'(bias));
    if (tag_valid) begin
      if (tag_last) begin
        push = 1'b1;
        if (fin_sum > (ACC_W+1)'(signed'(SAT_MAX))) begin
          push_res.data = SAT_MAX;
          push_res.sat  = 1'b1;
        end else if (fin_sum < (ACC_W+1)'(signed'(SAT_MIN))) begin
          push_res.data = SAT_MIN;
          push_res.sat  = 1'b1;
        end else begin
          push_res.data = fin_sum[DATA_W-1:0];
        end
        // ReLU clears the value but the clip flag still reports the pre-ReLU clip.
        if (relu_en && push_res.data[DATA_W-1]) begin
          push_res.data = '0;
        end
        acc_d   = '0;
        state_d = ST_EMPTY;
      end else begin
        acc_d   = ACC_W'(sat_add(64'(acc_q), 64'(signed'(prod)), ACC_W));
        state_d = ST_ACCUM;
      end
    end
  end

  assign pop = out_valid & out_ready;

  // Output FIFO; simultaneous push and pop both take effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_res;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr].data : '0;
  assign out_sat   = out_valid ? fifo_mem[rd_ptr].sat  : 1'b0;
  assign busy      = tag_any | (state_q == ST_ACCUM);

endmodule

// File: tb/tb_neuron_acc.sv
// Bench for neuron_acc: a transaction-level model (queues of in-flight ops and
// results) checked every cycle, plus directed vectors with literal results.
module tb_neuron_acc;

  localparam int MULT_LAT = 5;
  localparam int DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_last;
  logic        op_ready;
  logic [15:0] prod;
  logic [15:0] bias;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  logic [15:0] p_in;
  logic [15:0] mult_pipe [MULT_LAT];

  int n_checks = 0;
  int n_fail   = 0;

  neuron_acc #(.MULT_LAT(MULT_LAT), .ACC_W(24), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .op_ready  (op_ready),
    .prod      (prod),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the multiplier: the operand value issued with a tag comes out
  // as prod MULT_LAT edges later.
  always @(posedge clk) begin
    mult_pipe[0] <= p_in;
    for (int i = 1; i < MULT_LAT; i++) mult_pipe[i] <= mult_pipe[i-1];
  end
  assign prod = mult_pipe[MULT_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned due;
    bit          last;
    int          p;
  } op_t;

  op_t         inflight[$];
  logic [16:0] m_fifo[$];
  logic [16:0] m_popped[$];
  logic [16:0] dut_log[$];
  longint      m_acc = 0;
  bit          m_partial = 0;
  int unsigned edge_n = 0;

  function automatic int lasts_pending();
    int n = 0;
    foreach (inflight[i]) if (inflight[i].last) n++;
    return n;
  endfunction

  function automatic bit m_op_ready();
    return (m_fifo.size() + lasts_pending()) < DEPTH;
  endfunction

  function automatic longint clamp24(input longint v);
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic logic [16:0] finish_vec(input longint acc, input int p,
                                             input logic [15:0] b, input logic r);
    longint s;
    bit     sat;
    s   = acc + longint'(p) + longint'($signed(b));
    sat = 1'b0;
    if (s > 32767) begin
      s = 32767; sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768; sat = 1'b1;
    end
    if (r && s < 0) s = 0;
    return {sat, 16'(s)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight.delete();
      m_fifo.delete();
      m_acc     = 0;
      m_partial = 0;
    end else begin
      bit  take;
      op_t e;
      op_t n;
      take = op_valid && m_op_ready();
      edge_n++;
      if (out_ready && m_fifo.size() > 0) m_popped.push_back(m_fifo.pop_front());
      if (inflight.size() > 0 && inflight[0].due == edge_n) begin
        e = inflight.pop_front();
        if (e.last) begin
          m_fifo.push_back(finish_vec(m_acc, e.p, bias, relu_en));
          m_acc     = 0;
          m_partial = 0;
        end else begin
          m_acc     = clamp24(m_acc + longint'(e.p));
          m_partial = 1;
        end
      end
      if (take) begin
        n.due  = edge_n + MULT_LAT;
        n.last = op_last;
        n.p    = int'($signed(p_in));
        inflight.push_back(n);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_op_ready",  32'(op_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_sat",   32'(out_sat),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
    end else begin
      check("op_ready",  32'(op_ready),  32'(m_op_ready()));
      check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        check("out_data", 32'(out_data), 32'(m_fifo[0][15:0]));
        check("out_sat",  32'(out_sat),  32'(m_fifo[0][16]));
      end
      check("busy", 32'(busy), 32'(inflight.size() != 0 || m_partial));
    end
  end

  // Record DUT handshakes just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!reset && out_valid && out_ready) dut_log.push_back({out_sat, out_data});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic l, input logic [15:0] p);
    @(negedge clk);
    op_valid = v;
    op_last  = l;
    p_in     = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
  endtask

  // Sequencer-compliant issue: waits (bounded) for op_ready before asserting op_valid.
  task automatic issue(input logic l, input logic [15:0] p);
    int k;
    k = 0;
    @(negedge clk);
    while (!op_ready && k < 20) begin
      op_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    check("issue_wait", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_last  = l;
    p_in     = p;
  endtask

  task automatic wait_result(input string name, input logic [16:0] exp);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_seen"}, 32'(out_valid), 32'd1);
    check(name, 32'({out_sat, out_data}), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MULT_LAT; i++) mult_pipe[i] = 16'h0000;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_last   = 1'b0;
    p_in      = 16'h0000;
    bias      = 16'h0000;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Unit vector: 4 x 1.0 + 0.5, result visible exactly 6 edges after the last op.
    bias = 16'h0080;
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b1, 16'h0100);
    drive(1'b0, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        check("unit_early", 32'(out_valid), 32'd0);
      end else begin
        check("unit_valid", 32'(out_valid), 32'd1);
        check("unit_data",  32'(out_data),  32'h0480);
        check("unit_sat",   32'(out_sat),   32'd0);
      end
    end
    idle(4);

    // Saturation, both directions.
    bias = 16'h0000;
    for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 16'h4000);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("sat_pos", {1'b1, 16'h7FFF});
    for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 16'hC000);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("sat_neg", {1'b1, 16'h8000});
    idle(4);

    // ReLU on and off for -2.0.
    relu_en = 1'b1;
    drive(1'b1, 1'b1, 16'hFE00);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("relu_on", {1'b0, 16'h0000});
    idle(2);
    relu_en = 1'b0;
    drive(1'b1, 1'b1, 16'hFE00);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("relu_off", {1'b0, 16'hFE00});
    idle(4);

    // Backpressure: 4 single-element vectors against a stalled consumer.
    out_ready = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_op_ready", 32'(op_ready), 32'(i < 2));
      op_valid = 1'b1;
      op_last  = 1'b1;
      p_in     = 16'((i + 1) * 256);
    end
    idle(9);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    check("bp_held_ready", 32'(op_ready),  32'd0);
    check("bp_held_data",  32'(out_data),  32'h0100);
    check("bp_no_pop",     32'(dut_log.size()), 32'd0);
    out_ready = 1'b1;
    idle(6);
    check("bp_count", 32'(dut_log.size()), 32'd2);
    check("bp_first",  32'(dut_log.size() > 0 ? dut_log[0] : 17'h1FFFF), 32'h0100);
    check("bp_second", 32'(dut_log.size() > 1 ? dut_log[1] : 17'h1FFFF), 32'h0200);
    check("bp_ready_back", 32'(op_ready), 32'd1);
    idle(2);

    // Reset two elements into a five-element vector.
    dut_log.delete();
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b0, 16'h0100);
    @(negedge clk);
    op_valid = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mr_no_out", 32'(out_valid), 32'd0);
      check("mr_idle",   32'(busy),      32'd0);
    end
    check("mr_no_log", 32'(dut_log.size()), 32'd0);
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b1, 16'h0200);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("mr_fresh", {1'b0, 16'h0300});
    idle(4);

    // Streaming vectors of length 1, 3, 2.
    bias = 16'h0010;
    dut_log.delete();
    issue(1'b1, 16'h0200);
    issue(1'b0, 16'h0100);
    issue(1'b0, 16'h0100);
    issue(1'b1, 16'hFF00);
    issue(1'b0, 16'h0300);
    issue(1'b1, 16'h0050);
    idle(14);
    check("st_count", 32'(dut_log.size()), 32'd3);
    check("st_v1", 32'(dut_log.size() > 0 ? dut_log[0] : 17'h1FFFF), 32'h0210);
    check("st_v2", 32'(dut_log.size() > 1 ? dut_log[1] : 17'h1FFFF), 32'h0110);
    check("st_v3", 32'(dut_log.size() > 2 ? dut_log[2] : 17'h1FFFF), 32'h0360);

    // Accumulator clamp at 24 bits: overshoot upward, then pull back down.
    bias = 16'h0000;
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 16'h7FFF);
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 16'h8000);
    drive(1'b1, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);
    wait_result("acc_clamp", {1'b0, 16'hFFFF});
    idle(4);

    // Randomized traffic, including illegal op_valid and one mid-run reset.
    dut_log.delete();
    m_popped.delete();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c == 350) begin
        op_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
      end
      op_valid  = ($urandom_range(0, 9) < 7);
      op_last   = ($urandom_range(0, 3) == 0);
      p_in      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bias    = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511) - 256);
        relu_en = 1'($urandom_range(0, 1));
      end
    end
    out_ready = 1'b1;
    idle(15);
    check("rnd_count", 32'(dut_log.size()), 32'(m_popped.size()));
    for (int i = 0; i < dut_log.size() && i < m_popped.size(); i++) begin
      check("rnd_result", 32'(dut_log[i]), 32'(m_popped[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
